// File: rtl/rtc_pkg.sv
// Shared definitions for the real-time clock controller: register map,
// CTRL bit positions and the sequencing state encoding.
package rtc_pkg;

  localparam logic [2:0] CTRL_A     = 3'd0;
  localparam logic [2:0] PRESCALE_A = 3'd1;
  localparam logic [2:0] COUNT_A    = 3'd2;
  localparam logic [2:0] COMPARE_A  = 3'd3;
  localparam logic [2:0] STATUS_A   = 3'd4;

  localparam int CTRL_W         = 3;
  localparam int CTRL_EN_B      = 0;
  localparam int CTRL_AUTO_B    = 1;
  localparam int CTRL_IRQ_EN_B  = 2;
  localparam int STATUS_MATCH_B = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

endpackage

// File: rtl/rtc_prescaler.sv
// Prescale divider: pcnt runs 0..prescale while enabled and emits one tick
// per prescale+1 enabled clocks. A clear restarts the period from zero.
module rtc_prescaler #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] prescale,
  output logic             tick
);

  logic [WIDTH-1:0] pcnt;
  logic             at_top;

  assign at_top = (pcnt == prescale);
  assign tick   = en & at_top;

  // Clear has priority so a prescale rewrite never leaves pcnt above the limit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcnt <= '0;
    end else if (clr) begin
      pcnt <= '0;
    end else if (en) begin
      pcnt <= at_top ? '0 : pcnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/rtc_timer_ctrl.sv
// Memory-mapped RTC controller: register file, IDLE/RUN/HALT sequencer and
// compare/match logic around the prescaler. Writes are single-cycle strobes.
module rtc_timer_ctrl
  import rtc_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] PRESCALE_RST = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [2:0]       addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             tick,
  output logic             irq,
  output logic             running,
  output state_t           state_dbg
);

  state_t              state;
  logic [CTRL_W-1:0]   ctrl;
  logic [WIDTH-1:0]    prescale;
  logic [WIDTH-1:0]    count;
  logic [WIDTH-1:0]    compare;
  logic                match;

  logic                wr_ctrl;
  logic                wr_prescale;
  logic                wr_count;
  logic                wr_compare;
  logic                wr_status;
  logic                w1c;
  logic                ctrl_en;
  logic                ctrl_auto;
  logic                en_clearing;
  logic                run_en;
  logic                enter_run;
  logic [WIDTH-1:0]    cnt_inc;
  logic                hit;

  assign wr_ctrl     = we && (addr == CTRL_A);
  assign wr_prescale = we && (addr == PRESCALE_A);
  assign wr_count    = we && (addr == COUNT_A);
  assign wr_compare  = we && (addr == COMPARE_A);
  assign wr_status   = we && (addr == STATUS_A);
  assign w1c         = wr_status && wdata[STATUS_MATCH_B];

  assign ctrl_en     = ctrl[CTRL_EN_B];
  assign ctrl_auto   = ctrl[CTRL_AUTO_B];

  // A CTRL write dropping EN swallows a tick landing on the same edge.
  assign en_clearing = wr_ctrl && !wdata[CTRL_EN_B];
  assign run_en      = (state == RUN) && ctrl_en && !en_clearing;
  assign enter_run   = ctrl_en && ((state == IDLE) || ((state == HALT) && w1c));

  rtc_prescaler #(.WIDTH(WIDTH)) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .en       (run_en),
    .clr      (enter_run || wr_prescale),
    .prescale (prescale),
    .tick     (tick)
  );

  // A COUNT write on a tick edge takes precedence, so no match is evaluated.
  assign cnt_inc = count + WIDTH'(1);
  assign hit     = tick && !wr_count && (cnt_inc == compare);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      running <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ctrl_en) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        RUN: begin
          if (!ctrl_en) begin
            state   <= IDLE;
            running <= 1'b0;
          end else if (hit && !ctrl_auto) begin
            state   <= HALT;
            running <= 1'b0;
          end
        end
        HALT: begin
          if (!ctrl_en) begin
            state <= IDLE;
          end else if (w1c) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          running <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl     <= '0;
      prescale <= PRESCALE_RST;
      count    <= '0;
      compare  <= '0;
      match    <= 1'b0;
    end else begin
      if (wr_ctrl)     ctrl     <= wdata[CTRL_W-1:0];
      if (wr_prescale) prescale <= wdata;
      if (wr_compare)  compare  <= wdata;

      if (wr_count) begin
        count <= wdata;
      end else if (tick) begin
        if (hit) count <= ctrl_auto ? '0 : compare;
        else     count <= cnt_inc;
      end

      // A new match outranks a simultaneous write-1-to-clear.
      if (hit)      match <= 1'b1;
      else if (w1c) match <= 1'b0;
    end
  end

  assign irq       = match & ctrl[CTRL_IRQ_EN_B];
  assign state_dbg = state;

  always_comb begin
    rdata = '0;
    case (addr)
      CTRL_A:     rdata[CTRL_W-1:0]     = ctrl;
      PRESCALE_A: rdata                 = prescale;
      COUNT_A:    rdata                 = count;
      COMPARE_A:  rdata                 = compare;
      STATUS_A:   rdata[STATUS_MATCH_B] = match;
      default:    rdata                 = '0;
    endcase
  end

endmodule

// File: tb/tb_rtc_timer_ctrl.sv
// Directed bench for rtc_timer_ctrl: inputs change on negedge, outputs are
// sampled between negedge and the following posedge.
module tb_rtc_timer_ctrl;
  import rtc_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         we = 1'b0;
  logic [2:0]   addr = 3'd0;
  logic [W-1:0] wdata = '0;
  logic [W-1:0] rdata;
  logic         tick;
  logic         irq;
  logic         running;
  state_t       state_dbg;

  int checks = 0;
  int fails = 0;
  int tick_cnt = 0;
  int t0 = 0;

  rtc_timer_ctrl #(.WIDTH(W), .PRESCALE_RST(32'd0)) dut (
    .clk       (clk),
    .reset     (reset),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .tick      (tick),
    .irq       (irq),
    .running   (running),
    .state_dbg (state_dbg)
  );

  always #10 clk = ~clk;

  always @(negedge clk) begin
    #2;
    if (tick === 1'b1) tick_cnt++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reg(input string tag, input logic [2:0] a, input logic [W-1:0] exp);
    addr = a;
    #1;
    check(tag, rdata, exp);
  endtask

  // Call at a negedge; the write lands on the next posedge.
  task automatic wr(input logic [2:0] a, input logic [W-1:0] d);
    we = 1'b1;
    addr = a;
    wdata = d;
    @(negedge clk);
    we = 1'b0;
    wdata = '0;
  endtask

  initial begin
    // Reset values
    @(negedge clk);
    chk_reg("rst_ctrl", CTRL_A, 32'd0);
    chk_reg("rst_prescale", PRESCALE_A, 32'd0);
    chk_reg("rst_count", COUNT_A, 32'd0);
    chk_reg("rst_compare", COMPARE_A, 32'd0);
    chk_reg("rst_status", STATUS_A, 32'd0);
    check("rst_irq", W'(irq), 32'd0);
    check("rst_running", W'(running), 32'd0);
    check("rst_tick", W'(tick), 32'd0);
    check("rst_state", W'(state_dbg), W'(IDLE));
    reset = 1'b1;
    @(negedge clk);

    // Unmapped write ignored, unmapped reads zero
    wr(3'd5, 32'hDEAD_BEEF);
    chk_reg("unmapped5", 3'd5, 32'd0);
    chk_reg("unmapped7", 3'd7, 32'd0);
    chk_reg("unmapped_ctrl", CTRL_A, 32'd0);

    // Prescale 3: one tick per 4 clocks
    wr(PRESCALE_A, 32'd3);
    chk_reg("ps_readback", PRESCALE_A, 32'd3);
    wr(CTRL_A, 32'd1);
    t0 = tick_cnt;
    @(negedge clk);
    check("ps_running", W'(running), 32'd1);
    check("ps_state", W'(state_dbg), W'(RUN));
    repeat (3) @(negedge clk);
    chk_reg("ps_count0", COUNT_A, 32'd0);
    @(negedge clk);
    chk_reg("ps_count1", COUNT_A, 32'd1);
    repeat (4) @(negedge clk);
    chk_reg("ps_count2", COUNT_A, 32'd2);
    repeat (4) @(negedge clk);
    chk_reg("ps_count3", COUNT_A, 32'd3);
    check("ps_ticks", W'(tick_cnt - t0), 32'd3);
    wr(CTRL_A, 32'd0);
    @(negedge clk);
    check("ps_stop_state", W'(state_dbg), W'(IDLE));
    check("ps_stop_running", W'(running), 32'd0);
    chk_reg("ps_stop_count", COUNT_A, 32'd3);

    // One-shot match at COMPARE=5 with IRQ enabled
    wr(COUNT_A, 32'd0);
    wr(COMPARE_A, 32'd5);
    wr(PRESCALE_A, 32'd0);
    wr(CTRL_A, 32'd5);
    t0 = tick_cnt;
    repeat (5) @(negedge clk);
    chk_reg("os_count4", COUNT_A, 32'd4);
    check("os_state_run", W'(state_dbg), W'(RUN));
    @(negedge clk);
    chk_reg("os_count5", COUNT_A, 32'd5);
    chk_reg("os_match", STATUS_A, 32'd1);
    check("os_irq", W'(irq), 32'd1);
    check("os_state_halt", W'(state_dbg), W'(HALT));
    check("os_running", W'(running), 32'd0);
    repeat (3) @(negedge clk);
    chk_reg("os_frozen", COUNT_A, 32'd5);
    check("os_ticks", W'(tick_cnt - t0), 32'd5);
    wr(STATUS_A, 32'd1);
    check("os_irq_clr", W'(irq), 32'd0);
    chk_reg("os_status_clr", STATUS_A, 32'd0);
    check("os_resume", W'(state_dbg), W'(RUN));
    @(negedge clk);
    chk_reg("os_count6", COUNT_A, 32'd6);
    wr(CTRL_A, 32'd0);
    chk_reg("os_en_clr_tick", COUNT_A, 32'd6);
    @(negedge clk);
    check("os_idle", W'(state_dbg), W'(IDLE));

    // Auto-reload at COMPARE=3
    wr(COUNT_A, 32'd0);
    wr(COMPARE_A, 32'd3);
    wr(CTRL_A, 32'd7);
    repeat (2) @(negedge clk);
    chk_reg("ar_count1", COUNT_A, 32'd1);
    @(negedge clk);
    chk_reg("ar_count2", COUNT_A, 32'd2);
    chk_reg("ar_nomatch", STATUS_A, 32'd0);
    @(negedge clk);
    chk_reg("ar_count0", COUNT_A, 32'd0);
    chk_reg("ar_match", STATUS_A, 32'd1);
    check("ar_irq", W'(irq), 32'd1);
    check("ar_running", W'(running), 32'd1);
    wr(STATUS_A, 32'd1);
    chk_reg("ar_count1b", COUNT_A, 32'd1);
    chk_reg("ar_w1c", STATUS_A, 32'd0);
    @(negedge clk);
    chk_reg("ar_count2b", COUNT_A, 32'd2);
    wr(STATUS_A, 32'd1);
    chk_reg("ar_count0b", COUNT_A, 32'd0);
    chk_reg("ar_set_wins", STATUS_A, 32'd1);
    wr(CTRL_A, 32'd0);
    chk_reg("ar_stop_count", COUNT_A, 32'd0);

    // Wrap with COMPARE=0, IRQ disabled
    wr(COUNT_A, 32'hFFFF_FFFE);
    wr(COMPARE_A, 32'd0);
    wr(STATUS_A, 32'd1);
    wr(CTRL_A, 32'd1);
    repeat (2) @(negedge clk);
    chk_reg("wr_count_max", COUNT_A, 32'hFFFF_FFFF);
    chk_reg("wr_nomatch", STATUS_A, 32'd0);
    @(negedge clk);
    chk_reg("wr_count0", COUNT_A, 32'd0);
    chk_reg("wr_match", STATUS_A, 32'd1);
    check("wr_irq_masked", W'(irq), 32'd0);
    check("wr_halt", W'(state_dbg), W'(HALT));
    wr(CTRL_A, 32'd0);
    @(negedge clk);
    check("wr_idle", W'(state_dbg), W'(IDLE));
    wr(STATUS_A, 32'd1);

    // COUNT and COMPARE writes colliding with ticks
    wr(COUNT_A, 32'd0);
    wr(COMPARE_A, 32'd2);
    wr(CTRL_A, 32'd1);
    repeat (2) @(negedge clk);
    chk_reg("co_count1", COUNT_A, 32'd1);
    wr(COUNT_A, 32'd100);
    chk_reg("co_count100", COUNT_A, 32'd100);
    chk_reg("co_nomatch", STATUS_A, 32'd0);
    check("co_running", W'(running), 32'd1);
    @(negedge clk);
    chk_reg("co_count101", COUNT_A, 32'd101);
    wr(COMPARE_A, 32'd102);
    chk_reg("co_count102", COUNT_A, 32'd102);
    chk_reg("co_old_compare", STATUS_A, 32'd0);
    check("co_state", W'(state_dbg), W'(RUN));
    wr(COUNT_A, 32'd6);
    chk_reg("co_count6", COUNT_A, 32'd6);
    @(negedge clk);
    chk_reg("co_count7", COUNT_A, 32'd7);

    // Asynchronous reset mid-count
    reset = 1'b0;
    #1;
    chk_reg("ar_rst_count", COUNT_A, 32'd0);
    chk_reg("ar_rst_ctrl", CTRL_A, 32'd0);
    chk_reg("ar_rst_compare", COMPARE_A, 32'd0);
    check("ar_rst_irq", W'(irq), 32'd0);
    check("ar_rst_running", W'(running), 32'd0);
    check("ar_rst_state", W'(state_dbg), W'(IDLE));
    @(negedge clk);
    reset = 1'b1;
    t0 = tick_cnt;
    repeat (3) @(negedge clk);
    check("post_rst_ticks", W'(tick_cnt - t0), 32'd0);
    chk_reg("post_rst_count", COUNT_A, 32'd0);
    check("post_rst_running", W'(running), 32'd0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
